// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration in front of a single
// IDLE/SETUP/ACCESS APB transfer engine with a wait-state timeout.
module apb_arb_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic              req0_err,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic              req1_err,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    output logic [1:0]        fsm_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t     state;
    logic       prio;      // 0: req0 wins a tie, 1: req1 wins a tie
    logic       owner;
    logic [3:0] wait_cnt;
    logic       gnt0;
    logic       gnt1;

    assign fsm_state = state;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt0 = ~prio;
            gnt1 = prio;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    // A request transfers on a rising edge where valid and ready are both 1;
    // ready is only offered in IDLE, so a valid dropped before that is ignored.
    assign req0_ready = (state == IDLE) && !PRESET && gnt0;
    assign req1_ready = (state == IDLE) && !PRESET && gnt1;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            wait_cnt   <= 4'd0;
            PSELx      <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            req0_done  <= 1'b0;
            req0_err   <= 1'b0;
            req0_rdata <= '0;
            req1_done  <= 1'b0;
            req1_err   <= 1'b0;
            req1_rdata <= '0;
        end else begin
            req0_done <= 1'b0;
            req0_err  <= 1'b0;
            req1_done <= 1'b0;
            req1_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        PWRITE <= req0_write;
                        PADDR  <= req0_addr;
                        PWDATA <= req0_wdata;
                        owner  <= 1'b0;
                        prio   <= 1'b1;
                        PSELx  <= 1'b1;
                        state  <= SETUP;
                    end else if (req1_ready) begin
                        PWRITE <= req1_write;
                        PADDR  <= req1_addr;
                        PWDATA <= req1_wdata;
                        owner  <= 1'b1;
                        prio   <= 1'b0;
                        PSELx  <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= 4'd0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSELx   <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= IDLE;
                        if (owner) begin
                            req1_done <= 1'b1;
                            if (!PWRITE) req1_rdata <= PRDATA;
                        end else begin
                            req0_done <= 1'b1;
                            if (!PWRITE) req0_rdata <= PRDATA;
                        end
                    end else if (wait_cnt == 4'd15) begin
                        // Slave never answered: abort with an error, keep rdata.
                        PSELx   <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= IDLE;
                        if (owner) begin
                            req1_done <= 1'b1;
                            req1_err  <= 1'b1;
                        end else begin
                            req0_done <= 1'b1;
                            req0_err  <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of PADDR and of each requester address.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the width of PWDATA, PRDATA and the requester data buses.
REQ-003 The block SHALL have port PCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port PRESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have ports reqN_valid, input, 1 bit (N=0,1): requester N has a transfer pending.
REQ-006 The block SHALL have ports reqN_write, input, 1 bit: 1 for a write, 0 for a read.
REQ-007 The block SHALL have ports reqN_addr (input, ADDR_W) and reqN_wdata (input, DATA_W): transfer address and write data.
REQ-008 The block SHALL have ports reqN_ready, output, 1 bit: request accepted this cycle.
REQ-009 The block SHALL have ports reqN_done and reqN_err, outputs, 1 bit each: one-cycle completion pulse and its error flag.
REQ-010 The block SHALL have ports reqN_rdata, output, DATA_W: read data of N's last completed read.
REQ-011 The block SHALL have APB master outputs PSELx (1), PENABLE (1), PWRITE (1), PADDR (ADDR_W) and PWDATA (DATA_W).
REQ-012 The block SHALL have APB inputs PREADY (1) and PRDATA (DATA_W).

Function
REQ-013 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-014 In IDLE, reqN_ready SHALL be asserted combinationally, only for the granted requester and only while its reqN_valid=1.
REQ-015 The valid&ready edge SHALL capture write/addr/wdata into PWRITE/PADDR/PWDATA and move the FSM to SETUP.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant goes to the requester not granted last; a lone valid wins immediately.
REQ-017 After reset, the round-robin priority SHALL favour req0.
REQ-018 In SETUP: PSELx=1, PENABLE=0; the next state SHALL always be ACCESS.
REQ-019 In ACCESS: PSELx=1, PENABLE=1, with PADDR/PWRITE/PWDATA held stable until the transfer completes.
REQ-020 A 4-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle in which PREADY=0.
REQ-021 PREADY=1 sampled in ACCESS SHALL complete the transfer: FSM to IDLE, and the owner's reqN_done pulses high for exactly the next cycle with reqN_err=0.
REQ-022 On a read completion, PRDATA SHALL be latched into the owner's reqN_rdata; writes and errors SHALL leave reqN_rdata unchanged.
REQ-023 When the wait counter reaches 15 with PREADY still 0, the transfer SHALL abort: FSM to IDLE, and the owner's reqN_done=1 and reqN_err=1 for one cycle.
REQ-024 In IDLE, PSELx=PENABLE=0 and PADDR/PWRITE/PWDATA SHALL hold their last values.
REQ-025 Minimum transfer time SHALL be 3 cycles (IDLE accept, SETUP, ACCESS); back-to-back transfers always pass through IDLE.
REQ-026 A requester dropping valid before ready SHALL have no effect; a non-owner's done/err/rdata SHALL never change.

Reset
REQ-027 PRESET=1 SHALL immediately force: FSM IDLE, all APB outputs 0, reqN_ready/done/err 0, reqN_rdata 0, wait counter 0, priority to req0.
REQ-028 A transfer in flight when PRESET asserts SHALL be dropped without a done pulse.
REQ-029 After PRESET deasserts, the first acceptance SHALL occur on the next rising edge.

Verification
REQ-030 Single write: req0 write addr 0x10, data 0xA5A5_A5A5, PREADY=1 -> SETUP then ACCESS with PADDR=0x10, PWRITE=1; req0_done pulse 3 cycles after acceptance, err=0.
REQ-031 Read with 2 wait states: req1 read 0x20, PREADY low 2 ACCESS cycles, PRDATA=0x1234_5678 -> PENABLE high 3 cycles; req1_rdata=0x1234_5678, req1_done pulsed.
REQ-032 Contention: both valid continuously -> grants alternate req0, req1, req0, req1; no requester is granted twice in a row.
REQ-033 Timeout: PREADY held 0 -> after 16 ACCESS cycles, owner done=1, err=1; PSELx=0 next cycle; rdata unchanged.
REQ-034 Reset mid-ACCESS: PRESET pulsed high -> PSELx/PENABLE=0 with no clock edge, no done pulse; next request handled normally with req0 priority.
